moonbase_io_expander: RTL and testbench
=======================================

Name: moonbase_io_expander

Overview:
- Peripheral that sits directly downstream of the 8-bit CPU's multiplexed io_out bus, on the "external devices" side.
- Captures the 7-bit address the CPU strobes out and pairs the CPU's two consecutive nibble writes (high nibble, then low nibble) into byte registers.
- Returns 2-bit read data for the CPU's io_in[7:6] device-read path.
- Provides an 8-bit GPIO output port, a synchronised 8-bit GPIO input port and a prescaled reload timer.

Parameters:
- BASE_ADDR, 3'b111, device is selected when latched address[6:4] equals this value (default addresses 0x70-0x7F).
- PRESCALE, 1000, clk cycles per timer decrement; legal range 1..65535.
- SYNC_STAGES, 2, flop stages on gpio_in; legal range 2..3.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- bus_out  input  8  CPU io_out: [7] address strobe, [6:0] address when strobe=1; when strobe=0, [4] device write_n, [3:0] write nibble
- dev_data  output  2  read data, wired to CPU io_in[7:6]
- gpio_out  output  8  GPIO output register
- gpio_in  input  8  asynchronous GPIO inputs
- timer_tick  output  1  one-cycle pulse on each timer expiry

Behaviour:
- Reset (async, active-high) clears all state:
  - addr_q=0, hi_q=0, nib_phase=0, gpio_out=0x00, sync flops=0.
  - reload=0xFF, count=0xFF, prescaler=0, enable=0, flag=0, timer_tick=0.
  - dev_data reads 2'b00 while reset is held.
- Address latch: on any posedge with bus_out[7]=1, addr_q<=bus_out[6:0] and nib_phase<=0.
- sel = (addr_q[6:4]==BASE_ADDR); off = addr_q[3:0].
- Write cycle: a posedge with bus_out[7]=0, bus_out[4]=0 and sel=1.
  - nib_phase=0: hi_q<=bus_out[3:0], nib_phase<=1.
  - nib_phase=1: commit byte {hi_q, bus_out[3:0]} to register[off], nib_phase<=0.
  - Register is updated on the edge ending the second write cycle.
- Any non-write cycle with strobe=0 leaves nib_phase unchanged. Only a strobe resets it, so an orphan high nibble never commits.
- A third consecutive write cycle without a strobe starts a new pair.
- Writes with sel=0, or to undefined offsets, are ignored. nib_phase still toggles only when sel=1.
- Write map:
  - off0 GPIO_OUT.
  - off1 TIMER_RELOAD: also loads count and clears the prescaler.
  - off2 TIMER_CTRL: bit0 enable; bit1=1 clears flag (W1C, self-clearing); other bits ignored.
- Read (dev_data) is combinational from addr_q and registers, so it is valid the cycle after the strobe. sel=0 reads 2'b00.
- Read map:
  - off0 gpio_out[1:0]
  - off1 gin[1:0], off2 gin[3:2], off3 gin[5:4], off4 gin[7:6]
  - off5 {flag, enable}
  - off6 count[1:0], off7 count[3:2], off8 count[5:4], off9 count[7:6]
  - others 2'b00
- gin is gpio_in after SYNC_STAGES flops; input-to-readable latency is SYNC_STAGES cycles.
- Timer, when enable=1:
  - Prescaler counts 0..PRESCALE-1; at PRESCALE-1 it wraps to 0 and count decrements.
  - When count==0 at a decrement event: count<=reload, flag<=1, timer_tick=1 for that cycle.
  - reload=0 therefore expires every prescale period.
  - enable=0 freezes both prescaler and count.
- Simultaneous events:
  - Flag set and W1C clear on the same edge: set wins.
  - RELOAD write and expiry on the same edge: write wins, no tick.
- Mid-operation reset: async clear of all state; any pending nibble pair is lost.

Optional Feature:
- Macro MOONBASE_IO_TIMER_EN.
- Defined: timer, timer_tick and offsets 1, 2, 5-9 behave as above.
- Undefined: no timer logic. Writes to off1/off2 are ignored; reads at off5-9 return 2'b00; timer_tick is tied 0. GPIO behaviour is unchanged.

Decomposition:
- Package moonbase_io_pkg holds:
  - register offset constants (OFF_GPIO_OUT=0, OFF_TMR_RELOAD=1, OFF_TMR_CTRL=2, OFF_STATUS=5, OFF_CNT0..3=6..9);
  - CTRL bit indices (CTRL_EN=0, CTRL_CLR=1).
- Sub-module moonbase_io_timer (prescaler, count, reload, flag, tick) is instantiated only under MOONBASE_IO_TIMER_EN.

Test Plan:
- Reset mid-write:
  - Strobe 0x70, one write cycle with nibble 0xA, assert reset.
  - Then strobe 0x70 and a single write of 0x5 -> gpio_out=0x00 throughout.
- Byte pairing:
  - Strobe 0x70, write cycles 0xA then 0x5 -> gpio_out=0xA5 on the edge after the second cycle.
  - Read at 0x70 -> dev_data=2'b01.
- Address decode:
  - Strobe 0x30, writes 0xF, 0xF -> gpio_out unchanged.
  - Strobe 0x71, read -> gin[1:0].
- GPIO input sync:
  - gpio_in=0xC6, strobe 0x74 -> dev_data=2'b11 after 2 cycles.
  - Strobe 0x73 -> dev_data=2'b00.
- Timer (PRESCALE=4):
  - Write RELOAD=0x02 (0x71), CTRL=0x01 (0x72) -> timer_tick every 12 cycles; 0x75 reads 2'b11.
  - Write CTRL=0x03 -> flag cleared, 0x75 reads 2'b01.
- Collision:
  - Flag set and W1C on the same edge -> flag=1.
  - With MOONBASE_IO_TIMER_EN undefined, 0x75 reads 2'b00 and timer_tick stays 0.

Source files
------------

// File: rtl/moonbase_io_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// moonbase_io_pkg : register map, control bits and read-lane helper
// Rev 1.0
// ----------------------------------------------------------------------------
package moonbase_io_pkg;

  localparam logic [3:0] OFF_GPIO_OUT   = 4'd0;
  localparam logic [3:0] OFF_TMR_RELOAD = 4'd1;
  localparam logic [3:0] OFF_TMR_CTRL   = 4'd2;
  localparam logic [3:0] OFF_GIN0       = 4'd1;
  localparam logic [3:0] OFF_GIN1       = 4'd2;
  localparam logic [3:0] OFF_GIN2       = 4'd3;
  localparam logic [3:0] OFF_GIN3       = 4'd4;
  localparam logic [3:0] OFF_STATUS     = 4'd5;
  localparam logic [3:0] OFF_CNT0       = 4'd6;
  localparam logic [3:0] OFF_CNT1       = 4'd7;
  localparam logic [3:0] OFF_CNT2       = 4'd8;
  localparam logic [3:0] OFF_CNT3       = 4'd9;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } nib_phase_e;

  // Selects 2-bit lane idx (0 = bits [1:0]) of a byte.
  function automatic logic [1:0] lane2(input logic [7:0] v, input logic [1:0] idx);
    return v[{idx, 1'b0} +: 2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/moonbase_io_timer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// moonbase_io_timer : prescaled 8-bit reload down-counter with sticky flag
// Rev 1.0
// ----------------------------------------------------------------------------
module moonbase_io_timer #(
  parameter int PRESCALE = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reload_we,
  input  logic [7:0] reload_wdata,
  input  logic       ctrl_we,
  input  logic       ctrl_en,
  input  logic       ctrl_clr,
  output logic       enable,
  output logic       flag,
  output logic [7:0] count,
  output logic       tick
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [15:0] pre_q, pre_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  reload_q, reload_d;
  logic        en_q, en_d;
  logic        flag_q, flag_d;
  logic        tick_q, tick_d;
  logic        wrap;
  logic        expire;

  assign wrap   = en_q && (pre_q == PRE_MAX);
  // A reload write on the expiry edge cancels the expiry entirely.
  assign expire = wrap && (count_q == 8'd0) && !reload_we;

  always_comb begin
    pre_d    = pre_q;
    count_d  = count_q;
    reload_d = reload_q;
    en_d     = en_q;
    flag_d   = flag_q;
    tick_d   = expire;

    if (reload_we) begin
      reload_d = reload_wdata;
      count_d  = reload_wdata;
      pre_d    = '0;
    end else if (en_q) begin
      pre_d = wrap ? '0 : pre_q + 16'd1;
      if (wrap) count_d = (count_q == 8'd0) ? reload_q : count_q - 8'd1;
    end

    if (ctrl_we) begin
      en_d = ctrl_en;
      if (ctrl_clr) flag_d = 1'b0;
    end
    if (expire) flag_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q    <= '0;
      count_q  <= 8'hFF;
      reload_q <= 8'hFF;
      en_q     <= 1'b0;
      flag_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      en_q     <= en_d;
      flag_q   <= flag_d;
      tick_q   <= tick_d;
    end
  end

  assign enable = en_q;
  assign flag   = flag_q;
  assign count  = count_q;
  assign tick   = tick_q;

endmodule
`default_nettype wire

// File: rtl/moonbase_io_expander.sv
`default_nettype none
// ----------------------------------------------------------------------------
// moonbase_io_expander : nibble-paired CPU I/O peripheral (GPIO + optional
// timer, enabled by defining MOONBASE_IO_TIMER_EN).  Rev 1.0
// ----------------------------------------------------------------------------
module moonbase_io_expander
  import moonbase_io_pkg::*;
#(
  parameter logic [2:0] BASE_ADDR   = 3'b111,
  parameter int         PRESCALE    = 1000,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] bus_out,
  output logic [1:0] dev_data,
  output logic [7:0] gpio_out,
  input  logic [7:0] gpio_in,
  output logic       timer_tick
);

  if ((PRESCALE < 1) || (PRESCALE > 65535)) begin : g_bad_prescale
    $error("moonbase_io_expander: PRESCALE out of range");
  end
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 3)) begin : g_bad_sync
    $error("moonbase_io_expander: SYNC_STAGES out of range");
  end

  logic [6:0]                   addr_q, addr_d;
  logic [3:0]                   hi_q, hi_d;
  nib_phase_e                   phase_q, phase_d;
  logic [7:0]                   gpio_q, gpio_d;
  logic [SYNC_STAGES-1:0][7:0]  sync_q, sync_d;

  logic       strobe, sel, wr_cyc, commit;
  logic [3:0] off;
  logic [7:0] wbyte, gin;
  logic [1:0] rd_data;

  assign strobe = bus_out[7];
  assign sel    = (addr_q[6:4] == BASE_ADDR);
  assign off    = addr_q[3:0];
  assign wr_cyc = !strobe && !bus_out[4] && sel;
  assign commit = wr_cyc && (phase_q == PH_LO);
  assign wbyte  = {hi_q, bus_out[3:0]};
  assign gin    = sync_q[SYNC_STAGES-1];

  always_comb begin
    addr_d  = addr_q;
    hi_d    = hi_q;
    phase_d = phase_q;
    gpio_d  = gpio_q;
    if (strobe) begin
      addr_d  = bus_out[6:0];
      phase_d = PH_HI;
    end else if (wr_cyc) begin
      if (phase_q == PH_HI) begin
        hi_d    = bus_out[3:0];
        phase_d = PH_LO;
      end else begin
        phase_d = PH_HI;
      end
    end
    if (commit && (off == OFF_GPIO_OUT)) gpio_d = wbyte;
  end

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = gpio_in;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      hi_q    <= '0;
      phase_q <= PH_HI;
      gpio_q  <= '0;
      sync_q  <= '0;
    end else begin
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      phase_q <= phase_d;
      gpio_q  <= gpio_d;
      sync_q  <= sync_d;
    end
  end

`ifdef MOONBASE_IO_TIMER_EN
  logic       tmr_en, tmr_flag;
  logic [7:0] tmr_count;

  moonbase_io_timer #(
    .PRESCALE (PRESCALE)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .reload_we    (commit && (off == OFF_TMR_RELOAD)),
    .reload_wdata (wbyte),
    .ctrl_we      (commit && (off == OFF_TMR_CTRL)),
    .ctrl_en      (wbyte[CTRL_EN]),
    .ctrl_clr     (wbyte[CTRL_CLR]),
    .enable       (tmr_en),
    .flag         (tmr_flag),
    .count        (tmr_count),
    .tick         (timer_tick)
  );
`else
  assign timer_tick = 1'b0;
`endif

  always_comb begin
    rd_data = 2'b00;
    if (sel && !reset) begin
      case (off)
        OFF_GPIO_OUT:                         rd_data = gpio_q[1:0];
        OFF_GIN0, OFF_GIN1, OFF_GIN2, OFF_GIN3: rd_data = lane2(gin, off[1:0] - 2'd1);
`ifdef MOONBASE_IO_TIMER_EN
        OFF_STATUS:                           rd_data = {tmr_flag, tmr_en};
        OFF_CNT0, OFF_CNT1, OFF_CNT2, OFF_CNT3: rd_data = lane2(tmr_count, off[1:0] - 2'd2);
`endif
        default:                              rd_data = 2'b00;
      endcase
    end
  end

  assign dev_data = rd_data;
  assign gpio_out = gpio_q;

endmodule
`default_nettype wire

// File: tb/tb_moonbase_io_expander.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_moonbase_io_expander : directed scoreboard bench (PRESCALE=4, SYNC_STAGES=2)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_moonbase_io_expander;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] bus_out = 8'h10;
  logic [1:0] dev_data;
  logic [7:0] gpio_out;
  logic [7:0] gpio_in = 8'h00;
  logic       timer_tick;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_t;
  sb_t sb_q[$];

  moonbase_io_expander #(
    .BASE_ADDR   (3'b111),
    .PRESCALE    (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_out    (bus_out),
    .dev_data   (dev_data),
    .gpio_out   (gpio_out),
    .gpio_in    (gpio_in),
    .timer_tick (timer_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [7:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [7:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL sb_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(input logic [7:0] b);
    bus_out = b;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    step({1'b1, a});
    step({4'h0, d[7:4]});
    step({4'h0, d[3:0]});
    bus_out = 8'h10;
  endtask

  task automatic rd(input logic [6:0] a, input string tag, input logic [1:0] exp);
    push(tag, {6'd0, exp});
    step({1'b1, a});
    pop_check({6'd0, dev_data});
  endtask

  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      step(8'h10);
      if (timer_tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int ticks;

    // Reset state
    @(posedge clk);
    #1;
    push("rst_gpio", 8'h00);     pop_check(gpio_out);
    push("rst_dev", 8'h00);      pop_check({6'd0, dev_data});
    push("rst_tick", 8'h00);     pop_check({7'd0, timer_tick});
    reset = 1'b0;
    step(8'h10);
`ifdef MOONBASE_IO_TIMER_EN
    rd(7'h76, "rst_cnt0", 2'b11);
`else
    rd(7'h76, "rst_cnt0", 2'b00);
`endif

    // Reset in the middle of a nibble pair
    step(8'hF0);
    step(8'h0A);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    push("rst_hold_dev", 8'h00); pop_check({6'd0, dev_data});
    reset = 1'b0;
    step(8'hF0);
    step(8'h05);
    step(8'h10);
    push("rst_orphan", 8'h00);   pop_check(gpio_out);

    // Byte pairing
    step(8'hF0);
    step(8'h0A);
    push("pair_half", 8'h00);    pop_check(gpio_out);
    step(8'h05);
    push("pair_full", 8'hA5);    pop_check(gpio_out);
    step(8'h10);
    push("rd_gpio", 8'h01);      pop_check({6'd0, dev_data});

    // Third write without strobe starts a new pair
    step(8'h03);
    push("pair3_half", 8'hA5);   pop_check(gpio_out);
    step(8'h0E);
    push("pair3_full", 8'h3E);   pop_check(gpio_out);

    // Idle cycles keep the phase; a strobe discards an orphan nibble
    step(8'hF0);
    step(8'h04);
    step(8'h10);
    step(8'h1F);
    step(8'h08);
    push("idle_keep", 8'h48);    pop_check(gpio_out);
    step(8'hF0);
    step(8'h01);
    step(8'hF0);
    step(8'h02);
    step(8'h10);
    push("strobe_drop", 8'h48);  pop_check(gpio_out);

    // Address decode
    wr(7'h30, 8'hFF);
    push("unsel_wr", 8'h48);     pop_check(gpio_out);

    // GPIO input synchroniser latency
    gpio_in = 8'hC6;
    push("sync_1cyc", 8'h00);
    step(8'hF4);
    pop_check({6'd0, dev_data});
    push("sync_2cyc", 8'h03);
    step(8'h10);
    pop_check({6'd0, dev_data});
    rd(7'h71, "gin10", 2'b10);
    rd(7'h72, "gin32", 2'b01);
    rd(7'h73, "gin54", 2'b00);
    rd(7'h31, "unsel_rd", 2'b00);
    rd(7'h7C, "undef_off", 2'b00);

    // Timer programming
    wr(7'h71, 8'h02);
`ifdef MOONBASE_IO_TIMER_EN
    rd(7'h76, "reload_cnt", 2'b10);
`else
    rd(7'h76, "reload_cnt", 2'b00);
`endif
    wr(7'h72, 8'h01);
    push("tmr_gpio_keep", 8'h48); pop_check(gpio_out);

`ifdef MOONBASE_IO_TIMER_EN
    push("tick_first", 8'd12);
    wait_tick(n);
    pop_check(8'(n));
    push("tick_period", 8'd12);
    wait_tick(n);
    pop_check(8'(n));
    rd(7'h75, "status_set", 2'b11);
    wr(7'h72, 8'h03);
    rd(7'h75, "status_w1c", 2'b01);
    push("tick_after_clr", 8'd7);
    wait_tick(n);
    pop_check(8'(n));

    // Flag set and W1C on the same edge: set wins
    for (int i = 0; i < 9; i++) step(8'h10);
    step(8'hF2);
    step(8'h00);
    push("coll_tick", 8'h01);
    step(8'h03);
    pop_check({7'd0, timer_tick});
    rd(7'h75, "coll_flag", 2'b11);
`else
    ticks = 0;
    for (int i = 0; i < 40; i++) begin
      step(8'h10);
      if (timer_tick !== 1'b0) ticks++;
    end
    push("no_tick", 8'd0);       pop_check(8'(ticks));
    rd(7'h75, "status_off", 2'b00);
    wr(7'h72, 8'h03);
    rd(7'h75, "status_off2", 2'b00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
